// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the 16-bit, 8-register processor: latches the fetched
// instruction and steps it through FETCH/DECODE/EXEC/MEM/WB, driving register file and memory controls.
module multicycle_control_unit #(
  parameter int unsigned OPW = 4,
  parameter int unsigned RAW = 3,
  parameter int unsigned IW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IW-1:0]  instr,
  input  logic           instr_valid,
  input  logic           mem_ready,
  input  logic           alu_zero,
  output logic [IW-1:0]  ir_out,
  output logic [RAW-1:0] ra,
  output logic [RAW-1:0] rb,
  output logic [RAW-1:0] rw,
  output logic           rf_enable,
  output logic           reg_write,
  output logic           wb_sel,
  output logic           alu_src,
  output logic [2:0]     alu_op,
  output logic           mem_read,
  output logic           mem_write,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           illegal,
  output logic [2:0]     state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  localparam logic [OPW-1:0] OpR    = OPW'(0);
  localparam logic [OPW-1:0] OpAddi = OPW'(1);
  localparam logic [OPW-1:0] OpAndi = OPW'(2);
  localparam logic [OPW-1:0] OpLw   = OPW'(3);
  localparam logic [OPW-1:0] OpSw   = OPW'(4);
  localparam logic [OPW-1:0] OpBeq  = OPW'(5);
  localparam logic [OPW-1:0] OpJmp  = OPW'(6);

  state_e          state_q;
  logic [IW-1:0]   ir_q;
  logic            illegal_q;

  logic [OPW-1:0]  op;
  logic            is_r, is_addi, is_andi, is_lw, is_sw, is_beq, is_jmp, is_ill;
  logic [RAW-1:0]  fld_rs, fld_rt_r, fld_hi;
  logic [2:0]      dec_alu_op;
  logic            dec_alu_src;
  logic [RAW-1:0]  dest;

  assign op      = ir_q[IW-1 -: OPW];
  assign is_r    = (op == OpR);
  assign is_addi = (op == OpAddi);
  assign is_andi = (op == OpAndi);
  assign is_lw   = (op == OpLw);
  assign is_sw   = (op == OpSw);
  assign is_beq  = (op == OpBeq);
  assign is_jmp  = (op == OpJmp);
  assign is_ill  = (op > OpJmp);

  assign fld_hi   = ir_q[11:9];
  assign fld_rs   = ir_q[8:6];
  assign fld_rt_r = ir_q[5:3];

  // R-type takes its function from IR; loads/stores compute the address with ADD.
  always_comb begin
    dec_alu_op = 3'd0;
    if (is_r)         dec_alu_op = ir_q[2:0];
    else if (is_andi) dec_alu_op = 3'd2;
    else if (is_beq)  dec_alu_op = 3'd1;
  end

  assign dec_alu_src = is_addi | is_andi | is_lw | is_sw;
  assign dest        = is_r ? ir_q[11:9] : fld_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      unique case (state_q)
        StFetch: begin
          if (instr_valid) begin
            ir_q    <= instr;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (is_jmp) begin
            state_q <= StFetch;
          end else if (is_ill) begin
            illegal_q <= 1'b1;
            state_q   <= StFetch;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          if (is_beq)              state_q <= StFetch;
          else if (is_lw || is_sw) state_q <= StMem;
          else                     state_q <= StWb;
        end
        StMem: begin
          if (mem_ready) state_q <= is_sw ? StFetch : StWb;
        end
        StWb:    state_q <= StFetch;
        default: state_q <= StFetch;
      endcase
    end
  end

  // Read ports and ALU controls stay driven past DECODE so the ALU result (and the
  // memory address derived from it) is stable through MEM and WB.
  always_comb begin
    ra        = '0;
    rb        = '0;
    rw        = '0;
    rf_enable = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    alu_src   = 1'b0;
    alu_op    = 3'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    if (state_q != StFetch) begin
      rf_enable = 1'b1;
      ra        = fld_rs;
      rb        = is_r ? fld_rt_r : fld_hi;
      alu_op    = dec_alu_op;
      alu_src   = dec_alu_src;
    end
    unique case (state_q)
      StDecode: begin
        pc_load = is_jmp;
        pc_inc  = is_ill;
      end
      StExec: begin
        if (is_beq) begin
          pc_load = alu_zero;
          pc_inc  = ~alu_zero;
        end
      end
      StMem: begin
        mem_read  = is_lw;
        mem_write = is_sw;
        pc_inc    = is_sw & mem_ready;
      end
      StWb: begin
        rw        = dest;
        wb_sel    = is_lw;
        reg_write = (dest != '0);
        pc_inc    = 1'b1;
      end
      default: ;
    endcase
  end

  assign ir_out  = ir_q;
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized scoreboard bench for multicycle_control_unit: the driver pushes a per-instruction
// expectation from a high-level model; a monitor checks each instruction when its PC pulse appears.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        mem_ready;
  logic        alu_zero;
  logic [15:0] ir_out;
  logic [2:0]  ra, rb, rw;
  logic        rf_enable, reg_write, wb_sel, alu_src;
  logic [2:0]  alu_op;
  logic        mem_read, mem_write, pc_inc, pc_load, illegal;
  logic [2:0]  state;

  multicycle_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .mem_ready   (mem_ready),
    .alu_zero    (alu_zero),
    .ir_out      (ir_out),
    .ra          (ra),
    .rb          (rb),
    .rw          (rw),
    .rf_enable   (rf_enable),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .illegal     (illegal),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cycles;   // cycles spent outside FETCH
    bit         pinc;
    bit         pload;
    int         nwr;
    logic [2:0] rw;
    bit         wbs;
    int         rdc;
    int         wrc;
    bit         ill;
    bit         exec;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] aop;
    bit         asrc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ins, input bit az, input int stalls);
    exp_t       e;
    logic [3:0] op;
    op       = ins[15:12];
    e.ra     = ins[8:6];
    e.rb     = ins[11:9];
    e.rw     = ins[11:9];
    e.exec   = 1'b1;
    e.pinc   = 1'b1;
    e.pload  = 1'b0;
    e.nwr    = 0;
    e.wbs    = 1'b0;
    e.rdc    = 0;
    e.wrc    = 0;
    e.ill    = 1'b0;
    e.aop    = 3'd0;
    e.asrc   = 1'b0;
    e.cycles = 3;
    case (op)
      4'd0: begin
        e.rb  = ins[5:3];
        e.aop = ins[2:0];
        e.nwr = (ins[11:9] != 0) ? 1 : 0;
      end
      4'd1, 4'd2: begin
        e.aop  = (op == 4'd2) ? 3'd2 : 3'd0;
        e.asrc = 1'b1;
        e.nwr  = (ins[11:9] != 0) ? 1 : 0;
      end
      4'd3: begin
        e.asrc   = 1'b1;
        e.cycles = 4 + stalls;
        e.rdc    = 1 + stalls;
        e.wbs    = 1'b1;
        e.nwr    = (ins[11:9] != 0) ? 1 : 0;
      end
      4'd4: begin
        e.asrc   = 1'b1;
        e.cycles = 3 + stalls;
        e.wrc    = 1 + stalls;
      end
      4'd5: begin
        e.aop    = 3'd1;
        e.cycles = 2;
        e.pload  = az;
        e.pinc   = !az;
      end
      4'd6: begin
        e.exec   = 1'b0;
        e.cycles = 1;
        e.pinc   = 1'b0;
        e.pload  = 1'b1;
      end
      default: begin
        e.exec   = 1'b0;
        e.cycles = 1;
        e.ill    = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Monitor: samples mid-cycle, after the driver has settled the inputs.
  initial begin
    exp_t       e;
    int         cyc, nwr, rdc, wrc, both, stray;
    logic [2:0] rw_s, ra_s, rb_s, aop_s;
    bit         wbs_s, asrc_s, ex_s, ill_pend, ill_exp;
    cyc = 0; nwr = 0; rdc = 0; wrc = 0; both = 0; stray = 0;
    rw_s = 0; ra_s = 0; rb_s = 0; aop_s = 0; wbs_s = 0; asrc_s = 0; ex_s = 0;
    ill_pend = 0; ill_exp = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        sb.delete();
        cyc = 0; nwr = 0; rdc = 0; wrc = 0; both = 0; stray = 0; ex_s = 0;
        ill_pend = 0;
      end else begin
        if (ill_pend) begin
          chk("illegal_pulse", int'(illegal), int'(ill_exp));
          ill_pend = 0;
        end else if (illegal) begin
          stray++;
        end
        if (state == 3'd0) begin
          if (pc_inc || pc_load || reg_write || mem_read || mem_write) stray++;
        end else begin
          cyc++;
          if (reg_write) begin
            nwr++;
            rw_s  = rw;
            wbs_s = wb_sel;
          end
          if (mem_read)  rdc++;
          if (mem_write) wrc++;
          if (pc_inc && pc_load) both++;
          if (state == 3'd2) begin
            ex_s   = 1;
            ra_s   = ra;
            rb_s   = rb;
            aop_s  = alu_op;
            asrc_s = alu_src;
          end
          if (pc_inc || pc_load) begin
            if (sb.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_completion actual=pulse expected=none at %0t", $time);
            end else begin
              e = sb.pop_front();
              chk("cycles", cyc, e.cycles);
              chk("pc_inc", int'(pc_inc), int'(e.pinc));
              chk("pc_load", int'(pc_load), int'(e.pload));
              chk("pc_both", both, 0);
              chk("stray_ctrl", stray, 0);
              chk("reg_writes", nwr, e.nwr);
              chk("mem_read_cycles", rdc, e.rdc);
              chk("mem_write_cycles", wrc, e.wrc);
              chk("exec_seen", int'(ex_s), int'(e.exec));
              if (e.nwr > 0) begin
                chk("rw", int'(rw_s), int'(e.rw));
                chk("wb_sel", int'(wbs_s), int'(e.wbs));
              end
              if (e.exec && ex_s) begin
                chk("ra", int'(ra_s), int'(e.ra));
                chk("rb", int'(rb_s), int'(e.rb));
                chk("alu_op", int'(aop_s), int'(e.aop));
                chk("alu_src", int'(asrc_s), int'(e.asrc));
              end
              ill_pend = 1;
              ill_exp  = e.ill;
            end
            cyc = 0; nwr = 0; rdc = 0; wrc = 0; both = 0; stray = 0; ex_s = 0;
          end
        end
      end
    end
  end

  function automatic logic [23:0] ctrl_vec();
    return {ra, rb, rw, rf_enable, reg_write, wb_sel, alu_src, alu_op,
            mem_read, mem_write, pc_inc, pc_load, illegal, state};
  endfunction

  // Driver: enters at a negedge with the DUT in FETCH and returns the same way.
  task automatic run_instr(input logic [15:0] ins, input bit az, input int stalls,
                           input int idle);
    int memcnt;
    int n;
    sb.push_back(model(ins, az, stalls));
    repeat (idle) begin
      instr_valid = 1'b0;
      instr       = 16'($urandom);
      mem_ready   = 1'($urandom);
      alu_zero    = 1'($urandom);
      @(negedge clk);
    end
    instr       = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    memcnt = 0;
    n      = 0;
    while (state != 3'd0 && n < 60) begin
      instr_valid = 1'($urandom);
      instr       = 16'($urandom);
      alu_zero    = (state == 3'd2) ? az : 1'($urandom);
      if (state == 3'd3) begin
        mem_ready = (memcnt >= stalls);
        memcnt++;
      end else begin
        mem_ready = 1'($urandom);
      end
      n++;
      @(negedge clk);
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL fsm_timeout actual=%0d cycles expected=<60 instr=%h", n, ins);
    end
    instr_valid = 1'b0;
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] ins;
    int          n;
    rst         = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    alu_zero    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ir", int'(ir_out), 0);
    chk("reset_ctrl", int'(ctrl_vec()), 0);
    rst = 1'b0;
    @(negedge clk);

    run_instr(16'h0298, 1'b0, 0, 1);
    run_instr(16'h3485, 1'b0, 3, 0);
    run_instr(16'h5280, 1'b1, 0, 0);
    run_instr(16'h5280, 1'b0, 0, 2);
    run_instr(16'h1045, 1'b0, 0, 0);
    run_instr(16'hF000, 1'b0, 0, 0);
    run_instr(16'h6123, 1'b0, 0, 1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(7, 15));
      else                           op = 4'($urandom_range(0, 6));
      ins = {op, 12'($urandom)};
      run_instr(ins, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset while SW is waiting in MEM.
    sb.push_back(model(16'h4000, 1'b0, 100));
    instr       = 16'h4000;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    n = 0;
    while (state != 3'd3 && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("sw_in_mem_write", int'(mem_write), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", int'(state), 0);
    chk("midrst_mem_write", int'(mem_write), 0);
    chk("midrst_ir", int'(ir_out), 0);
    chk("midrst_ctrl", int'(ctrl_vec()), 0);
    rst = 1'b0;
    @(negedge clk);
    run_instr(16'h0e5a, 1'b0, 0, 1);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle control unit for the 16-bit, 8-register processor.
- Sits directly upstream of the register file and drives its read addresses, write address, write enable and enable.
- Latches each fetched instruction into an internal instruction register (IR) and steps it through FETCH/DECODE/EXEC/MEM/WB.
- Issues ALU, memory, write-back-select and PC controls with ready/valid-style stalls toward instruction and data memory.

Parameters:
- OPW, 4, opcode width, IR[15:12]
- RAW, 3, register address width
- IW, 16, instruction width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- instr  in  16  fetched instruction word
- instr_valid  in  1  instr valid this cycle
- mem_ready  in  1  data memory completed access
- alu_zero  in  1  ALU zero flag (EXEC cycle)
- ir_out  out  16  current IR contents
- ra  out  3  register file read address A
- rb  out  3  register file read address B
- rw  out  3  register file write address
- rf_enable  out  1  register file enable
- reg_write  out  1  register file write enable
- wb_sel  out  1  0=ALU result, 1=memory data
- alu_src  out  1  0=BusB, 1=sign-extended imm6
- alu_op  out  3  ALU function
- mem_read  out  1  data memory read request
- mem_write  out  1  data memory write request
- pc_inc  out  1  PC <= PC+1 this cycle
- pc_load  out  1  PC <= target this cycle
- illegal  out  1  one-cycle pulse, undefined opcode
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4

Behaviour:
- Registered state: state, IR, illegal.
- All other outputs are combinational from state and IR.
- Reset: state=FETCH, IR=0, illegal=0, every output 0. Applies mid-instruction; any in-flight memory request drops the next cycle.
- Encodings:
  - R-type (op 0000): rd=IR[11:9], rs=IR[8:6], rt=IR[5:3], func=IR[2:0]. alu_op=func: ADD, SUB, AND, OR, XOR, SLL, SRL, SLT = 0..7.
  - I-type: rt=IR[11:9], rs=IR[8:6], imm6=IR[5:0].
  - Opcodes: ADDI 0001 (alu_op 0), ANDI 0010 (alu_op 2), LW 0011, SW 0100, BEQ 0101 (alu_op 1), JMP 0110 (target IR[11:0]).
  - Opcodes 0111-1111 are illegal.
- FETCH:
  - If instr_valid: IR<=instr, go to DECODE.
  - Else hold; IR unchanged.
- DECODE:
  - rf_enable=1, ra=rs, rb = R-type ? rt : IR[11:9].
  - JMP: pc_load=1, go to FETCH.
  - Illegal: illegal<=1 for one cycle, pc_inc=1, go to FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - rf_enable=1, ra/rb held, alu_op per encoding.
  - alu_src=1 for ADDI/ANDI/LW/SW.
  - BEQ: pc_load=alu_zero, pc_inc=!alu_zero, go to FETCH.
  - LW/SW: alu_op=ADD, go to MEM.
  - Otherwise go to WB.
- MEM:
  - mem_read (LW) or mem_write (SW) stays asserted and addresses stay stable until mem_ready.
  - When mem_ready: SW sets pc_inc=1 and goes to FETCH; LW goes to WB.
  - Without mem_ready, hold indefinitely.
- WB:
  - rf_enable=1, rw = R-type ? rd : rt, wb_sel=1 for LW.
  - reg_write=1 only when rw!=0; writes to R0 are suppressed here.
  - pc_inc=1, go to FETCH.
- pc_inc and pc_load are never both 1.
- Exactly one of them pulses per completed instruction; none during stalls.
- Cycle counts with no stalls: R-type/ADDI/ANDI 4, LW 5, SW 4, BEQ 3, JMP 2, illegal 2.
- instr is ignored outside FETCH.
- mem_ready is ignored outside MEM.
- alu_zero is ignored outside EXEC for BEQ.

Test Plan:
- Reset, then instr_valid=1 with instr=0x0298 (ADD r1,r2,r3): states 0,1,2,4,0. In WB: rw=1, reg_write=1, pc_inc=1. In DECODE/EXEC: ra=2, rb=3, alu_op=0.
- LW 0x3485 (rt=2, rs=2, imm=5) with mem_ready low for 3 cycles: mem_read held 4 cycles in MEM. WB: wb_sel=1, reg_write=1, rw=2. Total 8 cycles.
- BEQ 0x5280: alu_zero=1 gives pc_load=1 in EXEC; alu_zero=0 gives pc_inc=1. Both return to FETCH after 3 cycles; reg_write never asserted.
- ADDI 0x1045 (rt=0): WB reached with rw=0 and reg_write=0; pc_inc=1.
- Opcode 0xF000: illegal pulses one cycle after DECODE, pc_inc=1, no reg_write/mem access. JMP 0x6123: pc_load=1 in DECODE.
- Assert rst during MEM of SW 0x4000 with mem_write=1: next cycle state=0, mem_write=0, IR=0, all outputs 0.
